// File: rtl/payload_pkg.sv
// Shared types for the payload dispatcher: control FSM states and the buffered beat.
package payload_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DROP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

endpackage

// File: rtl/payload_obuf.sv
// Single-entry output register holding one beat plus its destination; drives the per-PE valids.
// With PAYLOAD_DISPATCH_BCAST_EN a beat may target every PE and drains once all PEs have taken it.
module payload_obuf
    import payload_pkg::*;
#(
    parameter int NUM_PE  = 10,
    parameter int PE_ID_W = $clog2(NUM_PE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  beat_t              load_beat,
    input  logic [PE_ID_W-1:0] load_dest,
`ifdef PAYLOAD_DISPATCH_BCAST_EN
    input  logic               load_bcast,
`endif
    input  logic [NUM_PE-1:0]  out_ready,
    output logic [NUM_PE-1:0]  out_valid,
    output beat_t              beat_q,
    output logic               vld_q,
    output logic               drain,
    output logic               space_ok
);

    localparam logic [NUM_PE-1:0] ONE = {{(NUM_PE-1){1'b0}}, 1'b1};

    logic               vld_d;
    beat_t              beat_d;
    logic [PE_ID_W-1:0] dest_q, dest_d;
    logic [NUM_PE-1:0]  onehot, accepted;

    assign onehot   = vld_q ? (ONE << dest_q) : '0;
    assign accepted = out_valid & out_ready;
    assign space_ok = !vld_q || drain;

`ifdef PAYLOAD_DISPATCH_BCAST_EN
    logic              bcast_q, bcast_d;
    logic [NUM_PE-1:0] taken_q, taken_d;

    // A broadcast beat stays until the union of earlier and current takers covers every PE.
    assign out_valid = (vld_q && bcast_q) ? ~taken_q : onehot;
    assign drain     = vld_q && (bcast_q ? &(taken_q | accepted) : |accepted);
`else
    assign out_valid = onehot;
    assign drain     = |accepted;
`endif

    always_comb begin
        vld_d  = vld_q;
        beat_d = beat_q;
        dest_d = dest_q;
`ifdef PAYLOAD_DISPATCH_BCAST_EN
        bcast_d = bcast_q;
        taken_d = drain ? '0 : (taken_q | accepted);
`endif
        if (drain) vld_d = 1'b0;
        if (load) begin
            vld_d  = 1'b1;
            beat_d = load_beat;
            dest_d = load_dest;
`ifdef PAYLOAD_DISPATCH_BCAST_EN
            bcast_d = load_bcast;
            taken_d = '0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
            dest_q <= '0;
`ifdef PAYLOAD_DISPATCH_BCAST_EN
            bcast_q <= 1'b0;
            taken_q <= '0;
`endif
        end else begin
            vld_q  <= vld_d;
            beat_q <= beat_d;
            dest_q <= dest_d;
`ifdef PAYLOAD_DISPATCH_BCAST_EN
            bcast_q <= bcast_d;
            taken_q <= taken_d;
`endif
        end
    end

endmodule

// File: rtl/payload_dispatcher.sv
// Routes a serialized packet stream to one of NUM_PE processing elements, locking the destination per packet.
// Define PAYLOAD_DISPATCH_BCAST_EN to treat an all-ones destination as a broadcast to every PE.
module payload_dispatcher
    import payload_pkg::*;
#(
    parameter int NUM_PE  = 10,
    parameter int PE_ID_W = $clog2(NUM_PE),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [PE_ID_W-1:0] in_dest,
    input  logic               in_last,
    output logic [NUM_PE-1:0]  out_valid,
    input  logic [NUM_PE-1:0]  out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               busy,
    output logic               err_dest,
    output logic [CNT_W-1:0]   pkt_cnt
);

    localparam logic [PE_ID_W:0] NUM_PE_EXT = NUM_PE[PE_ID_W:0];

    state_e             state_q, state_d;
    logic [PE_ID_W-1:0] dest_q, dest_d, load_dest;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic  load, accept, hdr_ok, obuf_vld, drain, space_ok;
    beat_t obuf_beat, in_beat;

`ifdef PAYLOAD_DISPATCH_BCAST_EN
    logic load_bcast;
    assign load_bcast = (state_q == IDLE) ? &in_dest : &dest_q;
    assign hdr_ok     = ({1'b0, in_dest} < NUM_PE_EXT) || (&in_dest);
`else
    assign hdr_ok     = {1'b0, in_dest} < NUM_PE_EXT;
`endif

    // While dropping, beats never touch the output register, so the stream is never stalled.
    assign in_ready = (state_q == DROP) || space_ok;
    assign accept   = in_valid && in_ready;
    assign in_beat  = '{data: in_data, last: in_last};

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_dest = dest_q;
        cnt_d     = cnt_q + ((drain && obuf_beat.last) ? CNT_W'(1) : CNT_W'(0));
        case (state_q)
            IDLE: if (accept) begin
                dest_d = in_dest;
                if (hdr_ok) begin
                    load      = 1'b1;
                    load_dest = in_dest;
                    state_d   = in_last ? IDLE : STREAM;
                end else begin
                    err_d   = 1'b1;
                    state_d = in_last ? IDLE : DROP;
                end
            end
            STREAM: if (accept) begin
                load = 1'b1;
                if (in_last) state_d = IDLE;
            end
            DROP: if (accept && in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dest_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    payload_obuf #(
        .NUM_PE  (NUM_PE),
        .PE_ID_W (PE_ID_W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_beat (in_beat),
        .load_dest (load_dest),
`ifdef PAYLOAD_DISPATCH_BCAST_EN
        .load_bcast(load_bcast),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .beat_q    (obuf_beat),
        .vld_q     (obuf_vld),
        .drain     (drain),
        .space_ok  (space_ok)
    );

    assign out_data = obuf_beat.data;
    assign out_last = obuf_beat.last && obuf_vld;
    assign busy     = (state_q != IDLE);
    assign err_dest = err_q;
    assign pkt_cnt  = cnt_q;

endmodule
